// File: rtl/aes_uart_frame_ctrl.sv
// Frame controller between UART RX/TX and a combinational AES-128 core:
// collects key+plaintext, waits a fixed settle time, streams the ciphertext out.
module aes_uart_frame_ctrl #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] aes_key,
  output logic [127:0] aes_in,
  input  logic [127:0] aes_out,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned   TW          = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_RX   = 2'd0,
    S_WAIT = 2'd1,
    S_TX   = 2'd2
  } state_t;

  state_t state, state_next;

  // Only 31 bytes are ever held; the 32nd is taken straight from rx_data
  // when the key and plaintext registers are loaded.
  logic [247:0]  frame;
  logic [4:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    settle_cnt;
  logic [127:0]  ct;
  logic [3:0]    tx_cnt;

  logic rx_last;
  logic to_expire;
  logic tx_fire;
  logic tx_last;

  always_comb begin
    rx_last    = rx_valid && (byte_cnt == 5'd31);
    to_expire  = !rx_valid && (byte_cnt != 5'd0) && (to_cnt == TO_LAST);
    tx_fire    = tx_valid && tx_ready;
    tx_last    = tx_fire && (tx_cnt == 4'd15);
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_RX: begin
        if (rx_last) state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (settle_cnt == 8'd0) state_next = S_TX;
      end
      S_TX: begin
        busy = 1'b1;
        if (tx_last) state_next = S_RX;
      end
      default: state_next = S_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RX;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame      <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      settle_cnt <= '0;
      ct         <= '0;
      tx_cnt     <= '0;
      aes_key    <= '0;
      aes_in     <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_RX: begin
          if (rx_valid) begin
            frame    <= {frame[239:0], rx_data};
            byte_cnt <= byte_cnt + 5'd1;
            to_cnt   <= '0;
            if (rx_last) begin
              aes_key    <= frame[247:120];
              aes_in     <= {frame[119:0], rx_data};
              settle_cnt <= SETTLE_INIT;
            end
          end else if (to_expire) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
            err      <= 1'b1;
          end else if (byte_cnt != 5'd0) begin
            to_cnt <= to_cnt + TW'(1);
          end else begin
            to_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (rx_valid) err <= 1'b1;
          if (settle_cnt == 8'd0) begin
            ct       <= aes_out;
            tx_data  <= aes_out[127:120];
            tx_valid <= 1'b1;
            tx_cnt   <= '0;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_TX: begin
          if (rx_valid) err <= 1'b1;
          if (tx_fire) begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_last) begin
              tx_valid <= 1'b0;
              tx_data  <= '0;
              done     <= 1'b1;
            end else begin
              ct      <= {ct[119:0], 8'h00};
              tx_data <= ct[119:112];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_uart_frame_ctrl.md
Name: aes_uart_frame_ctrl

Overview:
- Sequences the combinational AES-128 encrypt core between the UART receiver and the UART transmitter.
- Collects a 32-byte frame from the UART RX byte stream: 16 key bytes, then 16 plaintext bytes.
- Drives the key and plaintext into the AES core from registers, waits a fixed settle time, then captures the ciphertext.
- Streams the 16 ciphertext bytes to the UART TX over a valid/ready handshake.
- Replaces the core's self-timed output flag with a deterministic, clocked schedule.

Parameters:
- SETTLE, 4: clock cycles allowed for the AES core to settle before the ciphertext is captured. Legal range is 1 to 255.
- TIMEOUT, 100000: maximum idle clock cycles allowed between RX bytes inside a partial frame. Legal minimum is 2.

Ports:
- clk  in  1  system clock; all flops use the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART RX.
- rx_valid  in  1  one-cycle strobe: rx_data is valid this cycle.
- aes_key  out  128  key to the AES core, registered.
- aes_in  out  128  plaintext to the AES core, registered.
- aes_out  in  128  ciphertext from the AES core.
- tx_data  out  8  byte to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the UART TX accepts the byte this cycle.
- busy  out  1  high in S_WAIT and S_TX.
- done  out  1  one-cycle pulse when the last ciphertext byte is accepted.
- err  out  1  one-cycle pulse on a frame timeout or on a dropped RX byte.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs go to 0: aes_key, aes_in, tx_data, tx_valid, busy, done, err.
  - The state goes to S_RX, and the byte, settle and timeout counters clear.
- Byte order: the first byte received maps to bits [127:120]; transmission also starts with bits [127:120].
- S_RX:
  - Each cycle with rx_valid=1 shifts rx_data into a 256-bit frame register (shift left by 8, new byte at LSB), increments the byte count (0..31) and clears the timeout counter.
  - On the edge E0 that accepts byte 31, load aes_key from frame[255:128] and aes_in from frame[127:0]. The byte count returns to 0 and the state goes to S_WAIT with the settle counter set to SETTLE-1.
  - While the byte count is nonzero and rx_valid=0, the timeout counter increments. When it reaches TIMEOUT-1: discard the partial frame, set the byte count to 0, pulse err, and stay in S_RX. aes_key and aes_in are not changed.
  - With the byte count at 0, the timeout counter is held at 0.
- S_WAIT:
  - The settle counter decrements every cycle.
  - On the edge where it equals 0: capture aes_out into the ciphertext register, set tx_data to aes_out[127:120], set tx_valid=1, and go to S_TX.
  - tx_valid therefore first rises SETTLE edges after E0.
- S_TX:
  - A byte is transferred when tx_valid=1 and tx_ready=1 in the same cycle. On each transfer, shift the ciphertext register left by 8 and drive the next byte.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - On the 16th transfer: tx_valid=0, tx_data=0, done pulses on the following cycle (the same edge that returns the state to S_RX).
- rx_valid in S_WAIT or S_TX: the byte is dropped, err pulses, and no state changes.
- If rx_valid and a timeout expiry coincide, the byte wins: it is accepted and the timeout counter clears.
- aes_key and aes_in hold their last values until the next complete frame.
- Reset mid-frame or mid-TX aborts immediately; no partial output follows the reset.

Test Plan:
- FIPS-197 vector: send key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff, with tx_ready=1. Required: tx_valid rises 4 cycles after the last RX byte; the TX bytes are 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; done pulses once.
- Backpressure: same frame with tx_ready toggling 1-0-0-1. Required: tx_data stays stable while stalled, the 16 bytes arrive in order, no byte is duplicated or lost.
- Timeout, using TIMEOUT=20: send 10 bytes, then idle for 20 cycles. Required: err pulses once, busy stays 0, and a following full 32-byte frame encrypts correctly.
- Overrun: pulse rx_valid (data 0xAA) during S_WAIT and during S_TX. Required: err pulses each time, and the ciphertext output is unchanged.
- Reset: assert rst_n=0 after the 8th TX byte. Required: tx_valid=0 and busy=0 at once; the next frame transmits all 16 bytes from byte 0.
- Back-to-back: two frames with different keys. Required: two correct 16-byte ciphertexts and two done pulses; aes_key equals key 2 after frame 2.
